moon_hit_manager: RTL

- Sits directly downstream of the moon boss sprite stage. Consumes moon_x/moon_y/moon_on and the player sprite's position and pixel-on flag.
- Detects player/moon contact once per frame and manages lives, invulnerability frames and game-over state.
- Drives the player blink enable for the renderer and a one-cycle hit pulse for sound/score logic.

---
 rtl/stg_pkg.sv | 15 +
 rtl/hit_box_cmp.sv | 27 ++
 rtl/moon_hit_manager.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stg_pkg.sv
// rtl/stg_pkg.sv - shared stage types and screen/game constants for the moon stage
package stg_pkg;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } state_t;

   localparam int SCREEN_W       = 384;
   localparam int SCREEN_H       = 448;
   localparam int DEF_LIVES      = 3;
   localparam int DEF_INV_FRAMES = 120;

endpackage

// File: rtl/hit_box_cmp.sv
// rtl/hit_box_cmp.sv - combinational square hit box: |ax-bx| < HIT_R and |ay-by| < HIT_R
module hit_box_cmp
   import stg_pkg::*;
#(
   parameter int HIT_R = 24
) (
   input  logic [9:0] i_ax,
   input  logic [9:0] i_ay,
   input  logic [9:0] i_bx,
   input  logic [9:0] i_by,
   output logic       o_hit
);

   logic signed [10:0] w_dx;
   logic signed [10:0] w_dy;
   logic [10:0]        w_adx;
   logic [10:0]        w_ady;

   // 11-bit signed difference covers the full 10-bit coordinate range without overflow
   assign w_dx  = $signed({1'b0, i_ax}) - $signed({1'b0, i_bx});
   assign w_dy  = $signed({1'b0, i_ay}) - $signed({1'b0, i_by});
   assign w_adx = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
   assign w_ady = w_dy[10] ? $unsigned(-w_dy) : $unsigned(w_dy);

   assign o_hit = (w_adx < 11'(HIT_R)) && (w_ady < 11'(HIT_R));

endmodule

// File: rtl/moon_hit_manager.sv
// rtl/moon_hit_manager.sv - player/moon contact, lives, invulnerability and game-over state
// Optional HIT_BOX_EN adds a coordinate hit box evaluated at frame_tick.
module moon_hit_manager
   import stg_pkg::*;
#(
   parameter int LIVES       = DEF_LIVES,
   parameter int INV_FRAMES  = DEF_INV_FRAMES,
   parameter int BLINK_SHIFT = 2,
   parameter int HIT_R       = 24
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_frame_tick,
   input  logic       i_restart,
   input  logic       i_player_on,
   input  logic       i_moon_on,
   input  logic [9:0] i_player_x,
   input  logic [9:0] i_player_y,
   input  logic [9:0] i_moon_x,
   input  logic [9:0] i_moon_y,
   output logic [2:0] o_lives,
   output logic       o_invuln,
   output logic       o_blink,
   output logic       o_hit,
   output logic       o_game_over
);

   localparam int CW = $clog2(INV_FRAMES + 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_lives;
   logic [2:0]      w_lives_nxt;
   logic [CW-1:0]   r_inv_cnt;
   logic [CW-1:0]   w_inv_cnt_nxt;
   logic            r_hit;
   logic            w_hit_nxt;
   logic            r_latch;
   logic            w_latch_nxt;
   logic            w_overlap;
   logic            w_box_hit;
   logic            w_outcome;

`ifdef HIT_BOX_EN
   hit_box_cmp #(
      .HIT_R (HIT_R)
   ) u_hit_box_cmp (
      .i_ax  (i_player_x),
      .i_ay  (i_player_y),
      .i_bx  (i_moon_x),
      .i_by  (i_moon_y),
      .o_hit (w_box_hit)
   );
`else
   logic w_unused_box;
   assign w_unused_box = ^{i_player_x, i_player_y, i_moon_x, i_moon_y, 10'(HIT_R)};
   assign w_box_hit    = 1'b0;
`endif

   assign w_overlap = i_player_on && i_moon_on;
   // overlap in the tick cycle itself still belongs to the frame being closed
   assign w_outcome = r_latch || w_overlap || w_box_hit;
   assign w_latch_nxt = i_frame_tick ? 1'b0 : (r_latch || w_overlap);

   always_comb begin
      w_state_nxt   = r_state;
      w_lives_nxt   = r_lives;
      w_inv_cnt_nxt = r_inv_cnt;
      w_hit_nxt     = 1'b0;
      if (i_frame_tick) begin
         case (r_state)
            ALIVE: begin
               if (w_outcome) begin
                  w_hit_nxt = 1'b1;
                  if (r_lives > 3'd1) begin
                     w_lives_nxt   = r_lives - 3'd1;
                     w_inv_cnt_nxt = CW'(INV_FRAMES);
                     w_state_nxt   = INVULN;
                  end else begin
                     w_lives_nxt = 3'd0;
                     w_state_nxt = DEAD;
                  end
               end
            end
            INVULN: begin
               if (r_inv_cnt > CW'(1)) begin
                  w_inv_cnt_nxt = r_inv_cnt - CW'(1);
               end else begin
                  w_inv_cnt_nxt = '0;
                  w_state_nxt   = ALIVE;
               end
            end
            DEAD: begin
               if (i_restart) begin
                  w_lives_nxt = 3'(LIVES);
                  w_state_nxt = ALIVE;
               end
            end
            default: begin
               w_state_nxt = ALIVE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= ALIVE;
         r_lives   <= 3'(LIVES);
         r_inv_cnt <= '0;
         r_hit     <= 1'b0;
         r_latch   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lives   <= w_lives_nxt;
         r_inv_cnt <= w_inv_cnt_nxt;
         r_hit     <= w_hit_nxt;
         r_latch   <= w_latch_nxt;
      end
   end

   assign o_lives     = r_lives;
   assign o_invuln    = (r_state == INVULN);
   assign o_blink     = (r_state == INVULN) && r_inv_cnt[BLINK_SHIFT];
   assign o_hit       = r_hit;
   assign o_game_over = (r_state == DEAD);

endmodule
